gig_basex_rx_framer: RTL and testbench
======================================

GIG_BASEX_RX_FRAMER -- requirements
Module: gig_basex_rx_framer

Interface
REQ-001 SHALL have parameter: none; all timing is fixed by this document.
REQ-002 SHALL have ports:
 - clk_125mhz, input, 1, sole clock for all logic.
 - rst, input, 1, reset; synchronous, active-high.
 - link_up, input, 1, PCS link status.
 - link_speed, input, lspeed_t (2), 10M=0, 100M=1, 1000M=2.
 - in_valid, input, 1, qualifies one code group per cycle.
 - in_is_ctl, input, 1, code group is a K character.
 - in_data, input, 8, decoded code group.
 - rx_dvalid, output, 1, pulses on each accepted sample.
 - rx_en, output, 1, GMII RX_DV.
 - rx_er, output, 1, GMII RX_ER.
 - rx_data, output, 8, GMII RXD.
 - code_err_count, output, 16, saturating count of framing/code errors.

Function
REQ-003 SHALL use these code groups, all with in_is_ctl=1: /S/ = 0xFB, /T/ = 0xFD, /R/ = 0xF7, /V/ = 0xFE, K28.5 = 0xBC.
REQ-004 SHALL register all outputs, with latency of 1 cycle from the accepted input to the output.
REQ-005 SHALL update rx_en, rx_er and rx_data only on cycles where rx_dvalid=1; outputs hold otherwise.
REQ-006 SHALL set replication factor N: 1 at 1000M, 10 at 100M, 100 at 10M.
REQ-007 SHALL latch N at /S/ acceptance; link_speed changes mid-frame are ignored until the next /S/.
REQ-008 SHALL maintain a 7-bit replication counter rep that:
 - increments on every in_valid byte;
 - wraps from N-1 to 0;
 - is set to 1 on /S/ acceptance, or to 0 when N=1.
REQ-009 SHALL accept a sample in IDLE on every in_valid byte; in other states, only on in_valid with rep==0.
REQ-010 SHALL implement a state machine with states IDLE, DATA and TERM.
REQ-011 In IDLE, /S/ SHALL output en=1, er=0, data=0x55 and move to DATA; any other sample SHALL output en=0, er=0, data=0.
REQ-012 In DATA, a non-control sample SHALL output en=1, er=0, data=in_data.
REQ-013 In DATA, /T/ SHALL output en=0, er=0 and move to TERM.
REQ-014 In DATA, /V/ or any K character other than /T/ and K28.5 SHALL:
 - output en=1, er=1, data=in_data;
 - increment the error count;
 - remain in DATA.
REQ-015 In DATA, K28.5 (early end) SHALL output en=1, er=1, data=0x00, increment the error count and move to IDLE.
REQ-016 In TERM, /R/ SHALL move to IDLE; any other sample SHALL increment the error count and move to IDLE; the output is en=0, er=0 in both cases.
REQ-017 When link_up=0 in DATA, the block SHALL:
 - force one rx_dvalid pulse with en=1, er=1, data=0x00 next cycle;
 - increment the error count;
 - go to IDLE.
REQ-018 While link_up=0, the block SHALL ignore inputs and hold state IDLE.
REQ-019 code_err_count SHALL saturate at 0xFFFF and never wrap.
REQ-020 SHALL count at most one error per cycle when simultaneous error events occur.

Reset
REQ-021 On rst, the block SHALL set state=IDLE, rep=0, N=1, code_err_count=0, rx_dvalid=0, rx_en=0, rx_er=0 and rx_data=0.
REQ-022 Reset mid-frame SHALL abort the frame silently, with no er pulse.
REQ-023 rst SHALL take priority over all other inputs.

Verification
REQ-024 1000M: /S/, 0x55×6, 0xD5, 0x01..0x40, /T/, /R/ -> rx_en high for 72 samples, first data 0x55; last sample data 0x40; error count 0.
REQ-025 100M: each byte of the same frame repeated 10× -> exactly 72 rx_en samples, one per 10 inputs, data identical to the 1000M case.
REQ-026 10M with 37 idle bytes before /S/ (rep misaligned) -> /S/ accepted immediately; subsequent samples taken every 100 inputs.
REQ-027 1000M: /S/, 3 data bytes, /V/, 2 data bytes, /T/, 0x50 -> er=1 on the /V/ sample only; code_err_count=2 (one for /V/, one for /T/ not followed by /R/).
REQ-028 link_up drops after 5 data bytes -> one cycle with en=1, er=1, data=0x00; then IDLE; code_err_count=1.
REQ-029 Force 0x10000 errors -> code_err_count reads 0xFFFF; rst -> 0.

Source files
------------

// File: rtl/gig_basex_rx_framer.sv
// gig_basex_rx_framer: turns decoded 1000BASE-X code groups into GMII RX signals,
// sampling one of every N bytes at 100M/10M replication.
module gig_basex_rx_framer (
    input  logic        clk_125mhz,
    input  logic        rst,
    input  logic        link_up,
    input  logic [1:0]  link_speed,
    input  logic        in_valid,
    input  logic        in_is_ctl,
    input  logic [7:0]  in_data,
    output logic        rx_dvalid,
    output logic        rx_en,
    output logic        rx_er,
    output logic [7:0]  rx_data,
    output logic [15:0] code_err_count
);
    localparam logic [7:0] K_S = 8'hFB;
    localparam logic [7:0] K_T = 8'hFD;
    localparam logic [7:0] K_R = 8'hF7;
    localparam logic [7:0] K_IDLE = 8'hBC;

    typedef enum logic [1:0] {IDLE, DATA, TERM} state_t;

    state_t      state_q;
    logic [6:0]  rep_q, n_q, n_sel, rep_d;
    logic        dvalid_q, en_q, er_q;
    logic [7:0]  data_q;
    logic [15:0] cnt_q;
    logic        is_s, is_t, is_r, is_k, drop, accept, start, err;

    assign n_sel  = link_speed == 2'd0 ? 7'd100 : link_speed == 2'd1 ? 7'd10 : 7'd1;
    assign is_s   = in_is_ctl && in_data == K_S;
    assign is_t   = in_is_ctl && in_data == K_T;
    assign is_r   = in_is_ctl && in_data == K_R;
    assign is_k   = in_is_ctl && in_data == K_IDLE;
    assign drop   = !link_up && state_q == DATA;
    assign accept = in_valid && link_up && (state_q == IDLE || rep_q == 7'd0);
    assign start  = accept && state_q == IDLE && is_s;
    // Several error sources may coincide; they fold into a single increment.
    assign err    = drop || (accept && ((state_q == DATA && in_is_ctl && !is_t) ||
                                        (state_q == TERM && !is_r)));
    assign rep_d  = start ? (n_sel == 7'd1 ? 7'd0 : 7'd1) :
                    (rep_q == n_q - 7'd1 ? 7'd0 : rep_q + 7'd1);

    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            state_q  <= IDLE;
            rep_q    <= 7'd0;
            n_q      <= 7'd1;
            cnt_q    <= 16'd0;
            dvalid_q <= 1'b0;
            en_q     <= 1'b0;
            er_q     <= 1'b0;
            data_q   <= 8'd0;
        end else begin
            dvalid_q <= accept || drop;
            if (in_valid && link_up)
                rep_q <= rep_d;
            if (start)
                n_q <= n_sel;
            if (err && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
            if (drop) begin
                en_q    <= 1'b1;
                er_q    <= 1'b1;
                data_q  <= 8'd0;
                state_q <= IDLE;
            end else if (!link_up) begin
                state_q <= IDLE;
            end else if (accept) begin
                case (state_q)
                    IDLE: begin
                        en_q   <= is_s;
                        er_q   <= 1'b0;
                        data_q <= is_s ? 8'h55 : 8'd0;
                        if (is_s)
                            state_q <= DATA;
                    end
                    DATA: begin
                        en_q   <= !is_t;
                        er_q   <= in_is_ctl && !is_t;
                        data_q <= (is_t || is_k) ? 8'd0 : in_data;
                        if (is_t)
                            state_q <= TERM;
                        else if (is_k)
                            state_q <= IDLE;
                    end
                    default: begin
                        en_q    <= 1'b0;
                        er_q    <= 1'b0;
                        data_q  <= 8'd0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_dvalid      = dvalid_q;
    assign rx_en          = en_q;
    assign rx_er          = er_q;
    assign rx_data        = data_q;
    assign code_err_count = cnt_q;
endmodule

// File: tb/tb_gig_basex_rx_framer.sv
// tb_gig_basex_rx_framer: directed stimulus pushes expected GMII samples into a
// queue; a negedge monitor pops and compares every rx_dvalid sample.
module tb_gig_basex_rx_framer;
    logic        clk_125mhz = 1'b0;
    logic        rst, link_up, in_valid, in_is_ctl;
    logic [1:0]  link_speed;
    logic [7:0]  in_data;
    logic        rx_dvalid, rx_en, rx_er;
    logic [7:0]  rx_data;
    logic [15:0] code_err_count;

    typedef struct packed {
        logic        en;
        logic        er;
        logic        dm;
        logic [7:0]  d;
        logic [31:0] due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        hold_en = 1'b0, hold_er = 1'b0;
    logic [7:0]  hold_d = 8'd0;

    gig_basex_rx_framer dut (
        .clk_125mhz(clk_125mhz), .rst(rst), .link_up(link_up), .link_speed(link_speed),
        .in_valid(in_valid), .in_is_ctl(in_is_ctl), .in_data(in_data),
        .rx_dvalid(rx_dvalid), .rx_en(rx_en), .rx_er(rx_er), .rx_data(rx_data),
        .code_err_count(code_err_count)
    );

    always #4 clk_125mhz = ~clk_125mhz;
    always @(posedge clk_125mhz) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    always @(negedge clk_125mhz) begin
        exp_t e;
        if (rx_dvalid) begin
            check("sample_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("latency", cyc, e.due);
                check("rx_en", rx_en, e.en);
                check("rx_er", rx_er, e.er);
                if (e.dm)
                    check("rx_data", rx_data, e.d);
            end
            hold_en = rx_en;
            hold_er = rx_er;
            hold_d  = rx_data;
        end else if (rst) begin
            hold_en = 1'b0;
            hold_er = 1'b0;
            hold_d  = 8'd0;
        end else begin
            check("hold", {rx_en, rx_er, rx_data}, {hold_en, hold_er, hold_d});
        end
    end

    task automatic expect_sample(input logic en, input logic er, input logic dm, input logic [7:0] d);
        exp_t e;
        e.en = en; e.er = er; e.dm = dm; e.d = d; e.due = cyc + 1;
        q.push_back(e);
    endtask

    task automatic send(input logic c, input logic [7:0] d, input logic ev,
                        input logic een, input logic eer, input logic edm, input logic [7:0] ed);
        in_valid = 1'b1; in_is_ctl = c; in_data = d;
        if (ev)
            expect_sample(een, eer, edm, ed);
        @(negedge clk_125mhz);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk_125mhz);
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b1; in_is_ctl = 1'b1; in_data = 8'hFB;
        repeat (2) @(negedge clk_125mhz);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk_125mhz);
    endtask

    // /S/, 0x55 x6, 0xD5, 0x01..0x40, /T/, then /R/; every byte repeated rep_n times.
    task automatic frame(input int rep_n);
        logic       c;
        logic [7:0] d;
        for (int k = 0; k <= 72; k++) begin
            c = (k == 0 || k == 72);
            d = k == 0 ? 8'hFB : k <= 6 ? 8'h55 : k == 7 ? 8'hD5 : k == 72 ? 8'hFD : 8'(k - 7);
            for (int r = 0; r < rep_n; r++) begin
                if (k == 20 && r == 0)
                    link_speed = 2'd2;
                if (k == 0)
                    send(c, d, r == 0, 1'b1, 1'b0, 1'b1, 8'h55);
                else if (k == 72)
                    send(c, d, r == 0, 1'b0, 1'b0, 1'b0, 8'h00);
                else
                    send(c, d, r == 0, 1'b1, 1'b0, 1'b1, d);
            end
        end
        for (int r = 0; r < rep_n; r++)
            send(1'b1, 8'hF7, 1'b1, 1'b0, 1'b0, r != 0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; link_up = 1'b1; link_speed = 2'd2;
        in_valid = 1'b1; in_is_ctl = 1'b1; in_data = 8'hFB;
        repeat (3) @(negedge clk_125mhz);
        check("reset_dvalid", rx_dvalid, 0);
        check("reset_outputs", {rx_en, rx_er, rx_data}, 0);
        check("reset_count", code_err_count, 0);
        rst = 1'b0; in_valid = 1'b0;
        idle(2);

        frame(1);
        idle(3);
        check("count_1000m", code_err_count, 0);

        link_speed = 2'd1;
        frame(10);
        idle(3);
        check("count_100m", code_err_count, 0);

        link_speed = 2'd0;
        for (int i = 0; i < 37; i++)
            send(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        frame(100);
        idle(3);
        check("count_10m", code_err_count, 0);

        do_reset();
        link_speed = 2'd2;
        send(1'b1, 8'hFB, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
        send(1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11);
        send(1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22);
        send(1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33);
        send(1'b1, 8'hFE, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFE);
        send(1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44);
        send(1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
        send(1'b1, 8'hFD, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send(1'b0, 8'h50, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(3);
        check("count_v_and_bad_term", code_err_count, 2);

        send(1'b1, 8'hFB, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
        send(1'b0, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1, 8'h66);
        send(1'b1, 8'hF7, 1'b1, 1'b1, 1'b1, 1'b1, 8'hF7);
        send(1'b1, 8'hBC, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        send(1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(3);
        check("count_early_end", code_err_count, 4);

        do_reset();
        send(1'b1, 8'hFB, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
        for (int i = 1; i <= 5; i++)
            send(1'b0, 8'(8'hA0 + i), 1'b1, 1'b1, 1'b0, 1'b1, 8'(8'hA0 + i));
        link_up = 1'b0; in_valid = 1'b1; in_is_ctl = 1'b1; in_data = 8'hFE;
        expect_sample(1'b1, 1'b1, 1'b1, 8'h00);
        repeat (4) @(negedge clk_125mhz);
        link_up = 1'b1;
        idle(2);
        check("count_link_drop", code_err_count, 1);
        send(1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(2);

        send(1'b1, 8'hFB, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
        send(1'b0, 8'h21, 1'b1, 1'b1, 1'b0, 1'b1, 8'h21);
        send(1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22);
        do_reset();
        check("midframe_reset_outputs", {rx_dvalid, rx_en, rx_er, rx_data}, 0);
        check("midframe_reset_count", code_err_count, 0);
        send(1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(2);

        send(1'b1, 8'hFB, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
        for (int i = 0; i < 65540; i++)
            send(1'b1, 8'hFE, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFE);
        idle(3);
        check("count_saturated", code_err_count, 16'hFFFF);
        do_reset();
        check("count_after_reset", code_err_count, 0);

        idle(3);
        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
